// File: rtl/imm_encode.sv
// Packs a signed immediate into the I/S/B/J fields of an instruction template, behind a one-entry output register.
// Define IMM_ENCODE_ALIGN_CHECK_EN to also flag odd B/J immediates as errors.
module imm_encode (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] imm,
  input  logic [1:0]  immsrc,
  input  logic [24:0] tmpl,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [24:0] instr,
  output logic        out_err,
  output logic [7:0]  err_count
);

  typedef enum logic {EMPTY, FULL} state_t;
  typedef enum logic [1:0] {FMT_I = 2'b00, FMT_S = 2'b01, FMT_B = 2'b10, FMT_J = 2'b11} fmt_t;

  state_t      state, state_next;
  fmt_t        fmt;
  logic        accept;
  logic [24:0] packed_instr;
  logic        range_err;
  logic        align_err;
  logic        err;

  assign fmt       = fmt_t'(immsrc);
  assign out_valid = (state == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;

  // tmpl bit k corresponds to instruction bit k+7
  always_comb begin
    packed_instr = tmpl;
    range_err    = 1'b0;
    case (fmt)
      FMT_I: begin
        packed_instr[24:13] = imm[11:0];
        range_err = !((&imm[31:11]) || !(|imm[31:11]));
      end
      FMT_S: begin
        packed_instr[24:18] = imm[11:5];
        packed_instr[4:0]   = imm[4:0];
        range_err = !((&imm[31:11]) || !(|imm[31:11]));
      end
      FMT_B: begin
        packed_instr[24]    = imm[12];
        packed_instr[23:18] = imm[10:5];
        packed_instr[4:1]   = imm[4:1];
        packed_instr[0]     = imm[11];
        range_err = !((&imm[31:12]) || !(|imm[31:12]));
      end
      FMT_J: begin
        packed_instr[24]    = imm[20];
        packed_instr[23:14] = imm[10:1];
        packed_instr[13]    = imm[11];
        packed_instr[12:5]  = imm[19:12];
        range_err = !((&imm[31:20]) || !(|imm[31:20]));
      end
      default: ;
    endcase
  end

`ifdef IMM_ENCODE_ALIGN_CHECK_EN
  assign align_err = immsrc[1] && imm[0];
`else
  assign align_err = 1'b0;
`endif

  assign err = range_err || align_err;

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (accept) state_next = FULL;
      FULL:  if (out_ready && !accept) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= EMPTY;
    else          state <= state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr     <= '0;
      out_err   <= 1'b0;
      err_count <= '0;
    end else if (accept) begin
      instr   <= packed_instr;
      out_err <= err;
      if (err && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_imm_encode.sv
// Directed-vector bench for imm_encode: packing, range boundaries, backpressure, reset and counter saturation.
module tb_imm_encode;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] imm;
  logic [1:0]  immsrc;
  logic [24:0] tmpl;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] instr;
  logic        out_err;
  logic [7:0]  err_count;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned exp_cnt = 0;

  localparam logic [1:0] F_I = 2'b00, F_S = 2'b01, F_B = 2'b10, F_J = 2'b11;

  imm_encode dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imm       (imm),
    .immsrc    (immsrc),
    .tmpl      (tmpl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .instr     (instr),
    .out_err   (out_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One request presented for one edge; result checked #1 after the edge.
  task automatic send(input string tag, input logic [1:0] src, input logic [31:0] v,
                      input logic [24:0] t, input logic rdy,
                      input logic [24:0] exp_instr, input logic exp_err);
    @(negedge clk);
    in_valid  = 1'b1;
    immsrc    = src;
    imm       = v;
    tmpl      = t;
    out_ready = rdy;
    @(posedge clk);
    #1;
    if (exp_err && exp_cnt < 255) exp_cnt++;
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, ".instr"}, {7'd0, instr}, {7'd0, exp_instr});
    check({tag, ".err"},   {31'd0, out_err}, {31'd0, exp_err});
    check({tag, ".cnt"},   {24'd0, err_count}, exp_cnt);
    in_valid = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b1;
    imm       = 32'h123;
    immsrc    = F_I;
    tmpl      = 25'h1ABCDEF;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst.valid", {31'd0, out_valid}, 32'd0);
    check("rst.instr", {7'd0, instr}, 32'd0);
    check("rst.err",   {31'd0, out_err}, 32'd0);
    check("rst.cnt",   {24'd0, err_count}, 32'd0);
    check("rst.ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // Packing vectors
    send("j_min",    F_J, 32'hFFF00000, 25'h0000100, 1'b1, 25'h1000000, 1'b0);
    send("i_m1",     F_I, 32'hFFFFFFFF, 25'h0,       1'b1, 25'h1FFE000, 1'b0);
    send("b_800",    F_B, 32'h00000800, 25'h0,       1'b1, 25'h0000001, 1'b0);
    send("s_5a5",    F_S, 32'h000005A5, 25'h0,       1'b1, 25'h0B40005, 1'b0);
    send("j_2",      F_J, 32'h00000002, 25'h1FFFFFF, 1'b1, 25'h000401F, 1'b0);
    send("i_pass",   F_I, 32'h00000000, 25'h1FFFFFF, 1'b1, 25'h0001FFF, 1'b0);
    // Range boundaries
    send("i_2047",   F_I, 32'h000007FF, 25'h0, 1'b1, 25'h0FFE000, 1'b0);
    send("i_m2049",  F_I, 32'hFFFFF7FF, 25'h0, 1'b1, 25'h0FFE000, 1'b1);
    send("b_m4096",  F_B, 32'hFFFFF000, 25'h0, 1'b1, 25'h1000000, 1'b0);
    send("b_4096",   F_B, 32'h00001000, 25'h0, 1'b1, 25'h1000000, 1'b1);
    send("j_2p20",   F_J, 32'h00100000, 25'h0, 1'b1, 25'h1000000, 1'b1);
`ifdef IMM_ENCODE_ALIGN_CHECK_EN
    send("b_odd",    F_B, 32'h00000003, 25'h0, 1'b1, 25'h0000002, 1'b1);
`else
    send("b_odd",    F_B, 32'h00000003, 25'h0, 1'b1, 25'h0000002, 1'b0);
`endif

    // Idle cycle with junk inputs: previous result drains, nothing new appears
    @(negedge clk);
    in_valid = 1'b0; imm = 32'hDEADBEEF; immsrc = F_S; tmpl = 25'h1555555; out_ready = 1'b1;
    @(posedge clk); #1;
    check("idle.valid", {31'd0, out_valid}, 32'd0);

    // Backpressure: A held, B blocked, then drain-and-accept on the same edge
    send("bp_a", F_I, 32'h00000005, 25'h0, 1'b0, 25'h000A000, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; immsrc = F_J; imm = 32'h2; tmpl = 25'h0; out_ready = 1'b0;
    #1;
    check("bp.ready_lo", {31'd0, in_ready}, 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      check("bp.hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp.hold_instr", {7'd0, instr}, 32'h000A000);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("bp.ready_hi", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    check("bp.b_valid", {31'd0, out_valid}, 32'd1);
    check("bp.b_instr", {7'd0, instr}, 32'h0004000);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("bp.drained", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset while FULL, no replay afterwards
    send("pre_rst", F_S, 32'h00000800, 25'h0, 1'b0, 25'h1000000, 1'b1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    exp_cnt = 0;
    check("arst.valid", {31'd0, out_valid}, 32'd0);
    check("arst.cnt",   {24'd0, err_count}, 32'd0);
    check("arst.instr", {7'd0, instr}, 32'd0);
    check("arst.ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("arst.noreplay", {31'd0, out_valid}, 32'd0);
    end

    // Error counter saturation
    for (int unsigned n = 0; n < 260; n++)
      send("s_sat", F_S, 32'h00000800, 25'h0, 1'b1, 25'h1000000, 1'b1);
    check("sat.final", {24'd0, err_count}, 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_encode.md
IMM_ENCODE -- requirements
Module: imm_encode

Interface
REQ-001 SHALL have ports (name direction width meaning):
- clk  in  1  rising-edge clock
- reset_n  in  1  async active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when high with in_valid
- imm  in  32  signed immediate to pack
- immsrc  in  2  format: 00 I, 01 S, 10 B, 11 J
- tmpl  in  25  template instr[31:7]; non-immediate fields (rd, rs1, rs2, funct3) pass through
- out_valid  out  1  result valid
- out_ready  in  1  consumer ready
- instr  out  25  packed instr[31:7]
- out_err  out  1  immediate out of range or misaligned for this result
- err_count  out  8  saturating count of errored results

REQ-002 SHALL use one clock, clk; reset_n is asynchronous, active-low.

Function
REQ-003 SHALL pack imm into the template fields, leaving all other bits equal to tmpl:
- I: [31:20]=imm[11:0]
- S: [31:25]=imm[11:5]; [11:7]=imm[4:0]
- B: [31]=imm[12]; [30:25]=imm[10:5]; [11:8]=imm[4:1]; [7]=imm[11]
- J: [31]=imm[20]; [30:21]=imm[10:1]; [20]=imm[11]; [19:12]=imm[19:12]

REQ-004 SHALL flag a range error when imm lies outside the signed range:
- I/S: -2048..2047
- B: -4096..4095
- J: -1048576..1048575

REQ-005 On a range error, SHALL still output the truncated packing and assert out_err with that result.

REQ-006 SHALL be a one-entry output register with states EMPTY and FULL:
- EMPTY to FULL on accept.
- FULL to EMPTY on out_ready with no accept.
- FULL stays FULL on simultaneous drain and accept.

REQ-007 SHALL drive in_ready = !out_valid || out_ready, combinationally.

REQ-008 SHALL have a latency of 1 cycle: a request accepted at edge N appears with out_valid=1 after edge N.

REQ-009 SHALL hold instr, out_err and out_valid stable while out_valid=1 and out_ready=0.

REQ-010 SHALL increment err_count by 1 per accepted errored request, saturating at 255 with no wrap.

REQ-011 SHALL ignore inputs while in_valid=0, and SHALL ignore imm, immsrc and tmpl on non-accept cycles.

Reset
REQ-012 While reset_n=0, SHALL hold: out_valid=0, instr=0, out_err=0, err_count=0, state EMPTY.

REQ-013 SHALL discard any held result when reset asserts mid-operation, and SHALL NOT replay it after reset.

REQ-014 in_ready SHALL read 1 during reset (state EMPTY), but no request is accepted while reset_n=0.

Configuration
REQ-015 With IMM_ENCODE_ALIGN_CHECK_EN defined, out_err SHALL also assert for B or J when imm[0]=1; the packing is unchanged and imm[0] is dropped.

REQ-016 Without IMM_ENCODE_ALIGN_CHECK_EN, imm[0] SHALL be silently dropped for B and J and SHALL never cause out_err.

Verification
REQ-017 J format, imm=0xFFF00000, tmpl=25'h0000100 (from 0x00008067) -> instr=25'h1000000, out_err=0, one cycle after accept.

REQ-018 I format, imm=0xFFFFFFFF, tmpl=0 -> instr=25'h1FFE000, out_err=0.

REQ-019 B format, imm=0x800, tmpl=0 -> instr=25'h0000001, out_err=0.

REQ-020 S format, imm=2048 -> out_err=1 and err_count=1; after 260 such requests, err_count=255.

REQ-021 out_ready=0 with two back-to-back requests -> first result held stable, in_ready=0 on the second; out_ready=1 -> first result drains, second is accepted the same edge and appears next cycle.

REQ-022 reset_n pulsed low while FULL -> out_valid=0 and err_count=0 immediately, with no clock edge needed; with IMM_ENCODE_ALIGN_CHECK_EN, B imm=3 -> out_err=1.
